// File: rtl/opcodes_pkg.sv
// Opcode and FSM state types shared by the iterative ALU, its datapath and its bench.
package opcodes_pkg;

  localparam int OP_W = 6;

  // New opcodes are appended so the original encodings 0..5 keep their values.
  typedef enum logic [OP_W-1:0] {
    ALU_OP_ADD  = 6'd0,
    ALU_OP_SUB  = 6'd1,
    ALU_OP_AND  = 6'd2,
    ALU_OP_OR   = 6'd3,
    ALU_OP_SRL  = 6'd4,
    ALU_OP_SLTU = 6'd5,
    ALU_OP_XOR  = 6'd6,
    ALU_OP_SLL  = 6'd7,
    ALU_OP_SRA  = 6'd8,
    ALU_OP_SLT  = 6'd9,
    ALU_OP_MUL  = 6'd10,
    ALU_OP_DIVU = 6'd11,
    ALU_OP_REMU = 6'd12
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_iter_state_t;

  function automatic logic is_iter_op(alu_op_t op);
    return (op == ALU_OP_MUL) || (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/result channel of alu_iter. Both sides use valid/ready: a transfer happens
// on a rising clk edge where valid && ready; valid never depends on ready of the same side.
interface alu_iter_if #(parameter int XLEN = 32);
  import opcodes_pkg::*;

  logic            in_valid;
  logic            in_ready;
  alu_op_t         in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_illegal
  );

endinterface

// File: rtl/alu_muldiv_iter.sv
// Bit-serial datapath: shift-add multiply and restoring divide, one bit per cycle,
// XLEN steps after start. result shows the value produced by the current step.
module alu_muldiv_iter
  import opcodes_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            abort,
  input  logic            start,
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic [CNT_W-1:0] cnt_q;
  alu_op_t          op_q;
  // hi: accumulator / partial remainder, lo: multiplier / dividend-then-quotient,
  // opnd: shifted multiplicand / divisor.
  logic [XLEN-1:0]  hi_q, lo_q, opnd_q;
  logic [XLEN-1:0]  hi_d, lo_d, opnd_d;
  logic [XLEN:0]    tmp, diff;

  assign busy = (cnt_q != '0);
  assign done = (cnt_q == CNT_W'(1));

  always_comb begin
    tmp    = {hi_q, lo_q[XLEN-1]};
    diff   = tmp - {1'b0, opnd_q};
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    if (op_q == ALU_OP_MUL) begin
      hi_d   = hi_q + (lo_q[0] ? opnd_q : '0);
      lo_d   = lo_q >> 1;
      opnd_d = opnd_q << 1;
    end else begin
      // A zero divisor never borrows, giving all-ones quotient and remainder = dividend.
      hi_d = diff[XLEN] ? tmp[XLEN-1:0] : diff[XLEN-1:0];
      lo_d = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end
    result = (op_q == ALU_OP_DIVU) ? lo_d : hi_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      op_q   <= ALU_OP_ADD;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else if (abort) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q  <= CNT_W'(XLEN);
      op_q   <= op;
      hi_q   <= '0;
      lo_q   <= (op == ALU_OP_MUL) ? b : a;
      opnd_q <= (op == ALU_OP_MUL) ? a : b;
    end else if (busy) begin
      cnt_q  <= cnt_q - CNT_W'(1);
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith/shift/compare ops plus multi-cycle MUL/DIVU/REMU,
// with a registered result held in DONE until the consumer takes it.
module alu_iter
  import opcodes_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  alu_iter_if.slave       bus,
  output alu_iter_state_t state
);

  localparam int SH_W = $clog2(XLEN);

  alu_iter_state_t state_q, state_d;
  logic [XLEN-1:0] res_q, res_d, alu_res, md_result;
  logic            ill_q, ill_d, alu_ill;
  logic            accept, md_start, md_busy, md_done;
  logic [SH_W-1:0] shamt;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    shamt   = bus.in_b[SH_W-1:0];
    case (bus.in_op)
      ALU_OP_ADD:  alu_res = bus.in_a + bus.in_b;
      ALU_OP_SUB:  alu_res = bus.in_a - bus.in_b;
      ALU_OP_AND:  alu_res = bus.in_a & bus.in_b;
      ALU_OP_OR:   alu_res = bus.in_a | bus.in_b;
      ALU_OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
      ALU_OP_SLL:  alu_res = bus.in_a << shamt;
      ALU_OP_SRL:  alu_res = bus.in_a >> shamt;
      ALU_OP_SRA:  alu_res = XLEN'($signed(bus.in_a) >>> shamt);
      ALU_OP_SLT:  alu_res = XLEN'($signed(bus.in_a) < $signed(bus.in_b));
      ALU_OP_SLTU: alu_res = XLEN'(bus.in_a < bus.in_b);
      ALU_OP_MUL, ALU_OP_DIVU, ALU_OP_REMU: alu_res = '0;
      default:     alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    case (state_q)
      IDLE:    bus.in_ready = 1'b1;
      DONE:    bus.in_ready = bus.out_ready;
      default: bus.in_ready = 1'b0;
    endcase
    if (flush) bus.in_ready = 1'b0;
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && bus.out_ready) state_d = IDLE;
        if (accept) begin
          if (is_iter_op(bus.in_op)) begin
            state_d  = BUSY;
            md_start = 1'b1;
            ill_d    = 1'b0;
          end else begin
            state_d = DONE;
            res_d   = alu_res;
            ill_d   = alu_ill;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = DONE;
          res_d   = md_result;
          ill_d   = 1'b0;
        end else if (!md_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d  = IDLE;
      md_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      ill_q   <= ill_d;
    end
  end

  alu_muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .abort  (flush),
    .start  (md_start),
    .op     (bus.in_op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign bus.out_valid   = (state_q == DONE);
  assign bus.out_result  = res_q;
  assign bus.out_illegal = ill_q;
  assign state           = state_q;

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter at XLEN 8, 32 and 64: vector table plus back-to-back,
// backpressure, flush and reset sequences. One width is driven at a time via sel.
module tb_alu_iter;
  import opcodes_pkg::*;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  int          sel;
  logic        drv_valid, drv_ready;
  logic [5:0]  drv_op;
  logic [63:0] drv_a, drv_b;

  alu_iter_if #(.XLEN(8))  if8 ();
  alu_iter_if #(.XLEN(32)) if32 ();
  alu_iter_if #(.XLEN(64)) if64 ();
  alu_iter_state_t st8, st32, st64;

  assign if8.in_valid  = drv_valid && (sel == 8);
  assign if8.in_op     = alu_op_t'(drv_op);
  assign if8.in_a      = drv_a[7:0];
  assign if8.in_b      = drv_b[7:0];
  assign if8.out_ready = drv_ready;
  assign if32.in_valid  = drv_valid && (sel == 32);
  assign if32.in_op     = alu_op_t'(drv_op);
  assign if32.in_a      = drv_a[31:0];
  assign if32.in_b      = drv_b[31:0];
  assign if32.out_ready = drv_ready;
  assign if64.in_valid  = drv_valid && (sel == 64);
  assign if64.in_op     = alu_op_t'(drv_op);
  assign if64.in_a      = drv_a;
  assign if64.in_b      = drv_b;
  assign if64.out_ready = drv_ready;

  alu_iter #(.XLEN(8))  dut8  (.clk(clk), .rst(rst), .flush(flush), .bus(if8),  .state(st8));
  alu_iter #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32), .state(st32));
  alu_iter #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(if64), .state(st64));

  logic            mon_valid, mon_in_ready, mon_ill;
  logic [63:0]     mon_res;
  alu_iter_state_t mon_state;
  assign mon_valid    = (sel == 8) ? if8.out_valid   : (sel == 64) ? if64.out_valid   : if32.out_valid;
  assign mon_in_ready = (sel == 8) ? if8.in_ready    : (sel == 64) ? if64.in_ready    : if32.in_ready;
  assign mon_ill      = (sel == 8) ? if8.out_illegal : (sel == 64) ? if64.out_illegal : if32.out_illegal;
  assign mon_res      = (sel == 8) ? 64'(if8.out_result) : (sel == 64) ? if64.out_result : 64'(if32.out_result);
  assign mon_state    = (sel == 8) ? st8 : (sel == 64) ? st64 : st32;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int          w;
    logic [5:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic run_vec(input vec_t v, input int idx);
    int   n;
    logic seen;
    sel = v.w;
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_op = v.op; drv_a = v.a; drv_b = v.b; drv_ready = 1'b1;
    @(negedge clk);
    chk($sformatf("v%0d in_ready", idx), 64'(mon_in_ready), 64'd1);
    @(posedge clk); #1;
    // Scramble inputs after accept; the result must depend only on the latched request.
    drv_valid = 1'b0;
    drv_op = 6'($urandom_range(0, 63));
    drv_a = {$urandom, $urandom};
    drv_b = {$urandom, $urandom};
    n = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      seen = mon_valid;
    end
    chk($sformatf("v%0d latency", idx), 64'(n), 64'(v.lat));
    chk($sformatf("v%0d result", idx), mon_res, v.exp);
    chk($sformatf("v%0d illegal", idx), 64'(mon_ill), 64'(v.ill));
    @(negedge clk);
    chk($sformatf("v%0d drained", idx), 64'(mon_valid), 64'd0);
  endtask

  logic [5:0]  bb_op[4];
  logic [63:0] bb_a[4], bb_b[4], bb_exp[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    rst = 1'b1; flush = 1'b0; sel = 32;
    drv_valid = 1'b0; drv_ready = 1'b0; drv_op = '0; drv_a = '0; drv_b = '0;
    repeat (3) @(posedge clk);
    #1;
    foreach (bb_op[i]) bb_op[i] = '0;
    for (int w = 8; w <= 64; w = w * 2) begin
      if (w == 16) continue;
      sel = w;
      @(negedge clk);
      chk($sformatf("reset w%0d out_valid", w), 64'(mon_valid), 64'd0);
      chk($sformatf("reset w%0d out_result", w), mon_res, 64'd0);
      chk($sformatf("reset w%0d out_illegal", w), 64'(mon_ill), 64'd0);
      chk($sformatf("reset w%0d state", w), 64'(mon_state), 64'(IDLE));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    vecs.push_back('{32, ALU_OP_ADD,  64'h7FFF_FFFF, 64'h1,         64'h8000_0000, 1'b0, 1});
    vecs.push_back('{32, ALU_OP_SUB,  64'h0,         64'h1,         64'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{32, ALU_OP_AND,  64'hF0F0,      64'hFF00,      64'hF000,      1'b0, 1});
    vecs.push_back('{32, ALU_OP_OR,   64'hF0F0,      64'h0F0F,      64'hFFFF,      1'b0, 1});
    vecs.push_back('{32, ALU_OP_SLL,  64'h1,         64'h3F,        64'h8000_0000, 1'b0, 1});
    vecs.push_back('{32, ALU_OP_SRL,  64'h8000_0000, 64'h24,        64'h0800_0000, 1'b0, 1});
    vecs.push_back('{32, ALU_OP_SLT,  64'h5,         64'hFFFF_FFFF, 64'h0,         1'b0, 1});
    vecs.push_back('{32, ALU_OP_SLTU, 64'h5,         64'hFFFF_FFFF, 64'h1,         1'b0, 1});
    vecs.push_back('{32, ALU_OP_MUL,  64'hFFFF_FFFF, 64'h3,         64'hFFFF_FFFD, 1'b0, 33});
    vecs.push_back('{32, ALU_OP_MUL,  64'h1_0000,    64'h1_0000,    64'h0,         1'b0, 33});
    vecs.push_back('{32, ALU_OP_DIVU, 64'd100,       64'd7,         64'd14,        1'b0, 33});
    vecs.push_back('{32, ALU_OP_REMU, 64'd100,       64'd7,         64'd2,         1'b0, 33});
    vecs.push_back('{32, ALU_OP_DIVU, 64'd5,         64'd0,         64'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{32, ALU_OP_REMU, 64'd5,         64'd0,         64'd5,         1'b0, 33});
    vecs.push_back('{32, 6'h3F,       64'h1234,      64'h5678,      64'h0,         1'b1, 1});
    vecs.push_back('{32, ALU_OP_ADD,  64'h1,         64'h1,         64'h2,         1'b0, 1});
    vecs.push_back('{32, 6'h0D,       64'h1,         64'h1,         64'h0,         1'b1, 1});
    vecs.push_back('{8,  ALU_OP_ADD,  64'h7F,        64'h1,         64'h80,        1'b0, 1});
    vecs.push_back('{8,  ALU_OP_SUB,  64'h0,         64'h1,         64'hFF,        1'b0, 1});
    vecs.push_back('{8,  ALU_OP_SLL,  64'h1,         64'hF,         64'h80,        1'b0, 1});
    vecs.push_back('{8,  ALU_OP_MUL,  64'hFF,        64'h3,         64'hFD,        1'b0, 9});
    vecs.push_back('{8,  ALU_OP_DIVU, 64'd100,       64'd7,         64'd14,        1'b0, 9});
    vecs.push_back('{8,  ALU_OP_REMU, 64'd100,       64'd7,         64'd2,         1'b0, 9});
    vecs.push_back('{8,  ALU_OP_DIVU, 64'd5,         64'd0,         64'hFF,        1'b0, 9});
    vecs.push_back('{8,  ALU_OP_REMU, 64'd5,         64'd0,         64'd5,         1'b0, 9});
    vecs.push_back('{64, ALU_OP_ADD,  64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1});
    vecs.push_back('{64, ALU_OP_SUB,  64'h0,         64'h1,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1});
    vecs.push_back('{64, ALU_OP_MUL,  64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65});
    vecs.push_back('{64, ALU_OP_DIVU, 64'd100,       64'd7,         64'd14,        1'b0, 65});
    vecs.push_back('{64, ALU_OP_REMU, 64'd100,       64'd7,         64'd2,         1'b0, 65});
    vecs.push_back('{64, ALU_OP_DIVU, 64'd5,         64'd0,         64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65});
    vecs.push_back('{64, ALU_OP_REMU, 64'd5,         64'd0,         64'd5,         1'b0, 65});

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Back-to-back single-cycle ops: one result per cycle.
    sel = 32;
    bb_op[0] = ALU_OP_SRA;  bb_a[0] = 64'h8000_0000; bb_b[0] = 64'h4; bb_exp[0] = 64'hF800_0000;
    bb_op[1] = ALU_OP_SLTU; bb_a[1] = 64'h1;         bb_b[1] = 64'h2; bb_exp[1] = 64'h1;
    bb_op[2] = ALU_OP_SLT;  bb_a[2] = 64'hFFFF_FFFF; bb_b[2] = 64'h0; bb_exp[2] = 64'h1;
    bb_op[3] = ALU_OP_XOR;  bb_a[3] = 64'hF0;        bb_b[3] = 64'hFF; bb_exp[3] = 64'h0F;
    @(posedge clk); #1;
    drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv_valid = 1'b1; drv_op = bb_op[i]; drv_a = bb_a[i]; drv_b = bb_b[i];
      @(negedge clk);
      chk($sformatf("b2b%0d in_ready", i), 64'(mon_in_ready), 64'd1);
      if (i > 0) begin
        chk($sformatf("b2b%0d out_valid", i - 1), 64'(mon_valid), 64'd1);
        chk($sformatf("b2b%0d result", i - 1), mon_res, bb_exp[i-1]);
      end
      @(posedge clk); #1;
    end
    drv_valid = 1'b0;
    @(negedge clk);
    chk("b2b3 out_valid", 64'(mon_valid), 64'd1);
    chk("b2b3 result", mon_res, bb_exp[3]);
    @(negedge clk);
    chk("b2b idle", 64'(mon_valid), 64'd0);

    // Backpressure: result held, no new request accepted.
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_op = ALU_OP_ADD; drv_a = 64'd2; drv_b = 64'd3; drv_ready = 1'b0;
    @(posedge clk); #1;
    drv_op = ALU_OP_SUB; drv_a = 64'd9; drv_b = 64'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d out_valid", i), 64'(mon_valid), 64'd1);
      chk($sformatf("bp%0d result", i), mon_res, 64'd5);
      chk($sformatf("bp%0d in_ready", i), 64'(mon_in_ready), 64'd0);
      @(posedge clk); #1;
    end
    drv_valid = 1'b0; drv_ready = 1'b1;
    @(negedge clk);
    chk("bp handshake valid", 64'(mon_valid), 64'd1);
    chk("bp handshake result", mon_res, 64'd5);
    @(negedge clk);
    chk("bp after handshake", 64'(mon_valid), 64'd0);

    // Flush in BUSY cycle 10 of a DIVU.
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_op = ALU_OP_DIVU; drv_a = 64'd100; drv_b = 64'd7;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; drv_valid = 1'b1; drv_op = ALU_OP_ADD; drv_a = 64'd1; drv_b = 64'd1;
    @(negedge clk);
    chk("flush in_ready", 64'(mon_in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; drv_valid = 1'b0;
    @(negedge clk);
    chk("flush out_valid", 64'(mon_valid), 64'd0);
    chk("flush in_ready after", 64'(mon_in_ready), 64'd1);
    chk("flush state", 64'(mon_state), 64'(IDLE));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | mon_valid;
    end
    chk("flush no result", 64'(seen), 64'd0);

    // Reset during BUSY of a MUL.
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_op = ALU_OP_MUL; drv_a = 64'd7; drv_b = 64'd9;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy out_valid", 64'(mon_valid), 64'd0);
    chk("rst busy out_result", mon_res, 64'd0);
    chk("rst busy out_illegal", 64'(mon_ill), 64'd0);
    chk("rst busy state", 64'(mon_state), 64'(IDLE));
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | mon_valid;
    end
    chk("rst no result", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
